// File: rtl/reg_nand_pipe.sv
`default_nettype none
// =============================================================================
// Module  : reg_nand_pipe
// Brief   : Valid/ready NAND pipeline: capture stage + DEPTH output stages.
//           Optional macro REG_NAND_PIPE_CNT_EN adds a saturating xfer_cnt.
// Revision: 1.0  initial release
// =============================================================================
module reg_nand_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
`ifdef REG_NAND_PIPE_CNT_EN
  ,
  output logic [15:0]      xfer_cnt
`endif
);

  logic [WIDTH-1:0] r_a0;
  logic [WIDTH-1:0] r_binv0;
  logic [WIDTH-1:0] r_data [1:DEPTH];
  logic [DEPTH:0]   r_valid;
  logic [DEPTH:0]   w_adv;
  logic [WIDTH-1:0] w_nand;
  logic             w_accept;

  // Stage k moves on when downstream is empty or moving too; resolved from the output back.
  always_comb begin
    w_adv        = '0;
    w_adv[DEPTH] = r_valid[DEPTH] & out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_adv[k] = r_valid[k] & (~r_valid[k+1] | w_adv[k+1]);
    end
  end

  assign in_ready  = ~r_valid[0] | w_adv[0];
  assign w_accept  = in_valid & in_ready;
  assign w_nand    = ~(r_a0 & ~r_binv0);
  assign out       = r_data[DEPTH];
  assign out_valid = r_valid[DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a0    <= '0;
      r_binv0 <= '0;
      r_valid <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_a0       <= in1;
        r_binv0    <= ~in2;
        r_valid[0] <= 1'b1;
      end else if (w_adv[0]) begin
        r_valid[0] <= 1'b0;
      end

      if (w_adv[0]) begin
        r_data[1]  <= w_nand;
        r_valid[1] <= 1'b1;
      end else if (w_adv[1]) begin
        r_valid[1] <= 1'b0;
      end

      for (int k = 2; k <= DEPTH; k++) begin
        if (w_adv[k-1]) begin
          r_data[k]  <= r_data[k-1];
          r_valid[k] <= 1'b1;
        end else if (w_adv[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
    end
  end

`ifdef REG_NAND_PIPE_CNT_EN
  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_adv[DEPTH] && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign xfer_cnt = r_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_nand_pipe.sv
`default_nettype none
// =============================================================================
// Module  : tb_reg_nand_pipe
// Brief   : Directed self-checking bench for reg_nand_pipe (WIDTH=1 and 8).
// Revision: 1.0  initial release
// =============================================================================
module tb_reg_nand_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       a_in_valid = 1'b0;
  logic       a_in_ready;
  logic [0:0] a_in1 = '0;
  logic [0:0] a_in2 = '0;
  logic       a_out_valid;
  logic       a_out_ready = 1'b0;
  logic [0:0] a_out;

  logic       b_in_valid = 1'b0;
  logic       b_in_ready;
  logic [7:0] b_in1 = '0;
  logic [7:0] b_in2 = '0;
  logic       b_out_valid;
  logic       b_out_ready = 1'b0;
  logic [7:0] b_out;

`ifdef REG_NAND_PIPE_CNT_EN
  logic [15:0] a_cnt;
  logic [15:0] b_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_nand_pipe #(.WIDTH(1), .DEPTH(3)) u_w1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in1(a_in1), .in2(a_in2),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out(a_out)
`ifdef REG_NAND_PIPE_CNT_EN
    , .xfer_cnt(a_cnt)
`endif
  );

  reg_nand_pipe #(.WIDTH(8), .DEPTH(3)) u_w8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in1(b_in1), .in2(b_in2),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out)
`ifdef REG_NAND_PIPE_CNT_EN
    , .xfer_cnt(b_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [0:0] v_i1 [4];
  logic [0:0] v_i2 [4];
  logic [0:0] v_exp [4];
  logic [7:0] exp8;

  initial begin
    v_i1  = '{1'b0, 1'b0, 1'b1, 1'b1};
    v_i2  = '{1'b0, 1'b1, 1'b0, 1'b1};
    v_exp = '{1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state
    step();
    check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_a_in_ready",  32'(a_in_ready),  32'd1);
    check("rst_a_out",       32'(a_out),       32'd0);
    check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    check("rst_b_in_ready",  32'(b_in_ready),  32'd1);
    check("rst_b_out",       32'(b_out),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Truth table on WIDTH=1, results appear 4 edges after each accept
    a_out_ready = 1'b1;
    for (int s = 0; s < 10; s++) begin
      if (s < 4) begin
        a_in_valid = 1'b1;
        a_in1 = v_i1[s];
        a_in2 = v_i2[s];
        check("tt_in_ready", 32'(a_in_ready), 32'd1);
      end else begin
        a_in_valid = 1'b0;
      end
      if (s >= 4 && s < 8) begin
        check("tt_out_valid", 32'(a_out_valid), 32'd1);
        check("tt_out", 32'(a_out), 32'(v_exp[s-4]));
      end else begin
        check("tt_out_idle", 32'(a_out_valid), 32'd0);
      end
      step();
    end

    // Stall: 6 offers, only 4 fit
    b_out_ready = 1'b0;
    for (int s = 0; s < 6; s++) begin
      b_in_valid = 1'b1;
      b_in1 = 8'hF0;
      b_in2 = 8'(s);
      check("stall_in_ready", 32'(b_in_ready), (s < 4) ? 32'd1 : 32'd0);
      step();
    end
    b_in_valid  = 1'b0;
    check("stall_hold_valid", 32'(b_out_valid), 32'd1);
    check("stall_hold_ready", 32'(b_in_ready), 32'd0);
    b_out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(b_in_ready), 32'd1);
    for (int s = 0; s < 5; s++) begin
      if (s < 4) begin
        check("drain_valid", 32'(b_out_valid), 32'd1);
        check("drain_data", 32'(b_out), 32'hFF);
      end else begin
        check("drain_empty", 32'(b_out_valid), 32'd0);
      end
      step();
    end

    // Back-to-back streaming, no bubbles
    for (int s = 0; s < 24; s++) begin
      if (s < 20) begin
        b_in_valid = 1'b1;
        b_in1 = 8'hAA;
        b_in2 = 8'(s * 7 + 3);
        check("stream_in_ready", 32'(b_in_ready), 32'd1);
      end else begin
        b_in_valid = 1'b0;
      end
      if (s >= 4) begin
        exp8 = ~(8'hAA & 8'((s - 4) * 7 + 3));
        check("stream_valid", 32'(b_out_valid), 32'd1);
        check("stream_data", 32'(b_out), 32'(exp8));
      end
      step();
    end
    b_in_valid = 1'b0;
    check("stream_done", 32'(b_out_valid), 32'd0);

    // Reset mid-stream with 3 results in flight
    for (int s = 0; s < 3; s++) begin
      b_in_valid = 1'b1;
      b_in1 = 8'hFF;
      b_in2 = 8'(s + 1);
      step();
    end
    b_in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(b_out_valid), 32'd0);
    check("mid_rst_out", 32'(b_out), 32'd0);
    check("mid_rst_in_ready", 32'(b_in_ready), 32'd1);
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    b_in_valid = 1'b1;
    b_in1 = 8'h0F;
    b_in2 = 8'h3C;
    check("post_rst_in_ready", 32'(b_in_ready), 32'd1);
    step();
    b_in_valid = 1'b0;
    check("post_rst_no_stale", 32'(b_out_valid), 32'd0);
    for (int e = 2; e <= 4; e++) begin
      step();
      if (e < 4) begin
        check("post_rst_wait", 32'(b_out_valid), 32'd0);
      end else begin
        check("post_rst_valid", 32'(b_out_valid), 32'd1);
        check("post_rst_data", 32'(b_out), 32'hF3);
      end
    end
    step();
    check("post_rst_single", 32'(b_out_valid), 32'd0);

`ifdef REG_NAND_PIPE_CNT_EN
    check("cnt_after_rst", 32'(a_cnt), 32'd0);
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in1 = 1'b1;
    a_in2 = 1'b0;
    for (int s = 0; s < 70010; s++) begin
      step();
    end
    check("cnt_saturated", 32'(a_cnt), 32'hFFFF);
    step();
    step();
    check("cnt_held", 32'(a_cnt), 32'hFFFF);
    a_in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("cnt_cleared", 32'(a_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_nand_pipe.md
REG_NAND_PIPE -- requirements
Module: reg_nand_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 1, data bit width per operand (legal range 1..64).
REQ-002 SHALL have parameter DEPTH, default 3, number of output register stages after the capture stage (legal range 1..16).
REQ-003 SHALL have port clk  input  1  single clock; all flops are rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream offers in1/in2 this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts the offer this cycle.
REQ-007 SHALL have port in1  input  WIDTH  operand A.
REQ-008 SHALL have port in2  input  WIDTH  operand B.
REQ-009 SHALL have port out_valid  output  1  out holds a valid result.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out this cycle.
REQ-011 SHALL have port out  output  WIDTH  registered result.

Function
REQ-012 SHALL register a transfer on a rising clk edge when in_valid and in_ready are both 1, and deliver one when out_valid and out_ready are both 1.
REQ-013 SHALL have a capture stage (stage 0) holding in1 and the bitwise inverse of in2, plus a valid bit.
REQ-014 SHALL compute per bit result = NAND(stage0_A, NOT stage0_Binv), i.e. ~(in1 & in2), combinationally between stage 0 and stage 1.
REQ-015 SHALL pass results through DEPTH stages (1..DEPTH), each with a WIDTH data register and a valid bit; out and out_valid are driven directly from stage DEPTH.
REQ-016 SHALL have a latency of exactly DEPTH+1 clk edges from acceptance to out_valid with out_ready held 1.
REQ-017 SHALL sustain one transfer per cycle when out_ready is held 1.
REQ-018 SHALL advance stage k (0..DEPTH-1) into stage k+1 when stage k+1 is empty or is itself advancing in the same cycle; stage DEPTH empties when it delivers.
REQ-019 SHALL drive in_ready = NOT stage0_valid OR stage 0 advancing in the same cycle, so a full pipeline with out_ready 1 still accepts input.
REQ-020 SHALL, when out_ready is 0, hold out and out_valid stable and collapse bubbles, so it buffers up to DEPTH+1 results before in_ready drops to 0.
REQ-021 SHALL keep data registers unchanged on stalls; no result is dropped or duplicated.
REQ-022 SHALL, on simultaneous accept and deliver in a full pipeline, keep the occupancy unchanged and preserve ordering.
REQ-023 SHALL ignore in1/in2 when in_valid is 0, and leave out undefined-but-stable when out_valid is 0.

Reset
REQ-024 SHALL, while rst_n is 0, asynchronously clear all valid bits to 0, which forces out_valid to 0 and in_ready to 1.
REQ-025 SHALL reset all data registers to 0, so that out = 0 during reset.
REQ-026 SHALL discard all in-flight results when reset is asserted mid-operation.
REQ-027 SHALL accept a transfer on the first rising clk edge after rst_n deasserts.

Configuration
REQ-028 SHALL, with macro REG_NAND_PIPE_CNT_EN defined, add output port xfer_cnt (16 bits), which counts output transfers, is reset to 0 by rst_n, and saturates at 0xFFFF.
REQ-029 SHALL, without REG_NAND_PIPE_CNT_EN, omit both the xfer_cnt port and its counter logic, with all other behaviour identical.

Verification
REQ-030 SHALL cover: WIDTH=1, DEPTH=3, out_ready=1, (in1,in2) = (0,0),(0,1),(1,0),(1,1) on consecutive cycles -> out = 1,1,1,0 on consecutive cycles, starting 4 cycles after the first accept.
REQ-031 SHALL cover: WIDTH=8, DEPTH=3, out_ready=0, 6 offers of in1=0xF0 with in2=0x00..0x05 -> exactly 4 accepted, then in_ready=0; releasing out_ready -> 4 results 0xFF in order, and in_ready rises in the same cycle as the first delivery.
REQ-032 SHALL cover: full pipeline, in_valid=1 and out_ready=1 held for 20 cycles with in1=0xAA and in2 incrementing -> 20 back-to-back results ~(0xAA & in2) with no bubble.
REQ-033 SHALL cover: rst_n pulsed low mid-stream with 3 results in flight -> out_valid=0 and out=0 immediately, no stale result after release, and the first post-reset input emerges after DEPTH+1 cycles.
REQ-034 SHALL cover: with REG_NAND_PIPE_CNT_EN defined, 70000 deliveries -> xfer_cnt = 0xFFFF held; after reset, xfer_cnt = 0.
